// File: rtl/mpq_host_sequencer_if.sv
// rtl/mpq_host_sequencer_if.sv - host load/command and MPQ-side signal bundle for the sequencer
interface mpq_host_sequencer_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;

    logic          hc_valid;
    logic [2:0]    hc_cmd;
    logic [DW-1:0] hc_index;
    logic [DW-1:0] hc_value;
    logic          hc_ready;

    logic          mpq_data_valid;
    logic [DW-1:0] mpq_data;
    logic          mpq_cmd_valid;
    logic [2:0]    mpq_cmd;
    logic [DW-1:0] mpq_index;
    logic [DW-1:0] mpq_value;
    logic          mpq_busy;
    logic          mpq_done;

    logic [5:0]    heap_size;
    logic          err;
    logic [7:0]    err_cnt;
    logic          seq_done;

    // Host and MPQ environment side.
    modport master (
        output in_valid, in_data, in_last,
        input  in_ready,
        output hc_valid, hc_cmd, hc_index, hc_value,
        input  hc_ready,
        input  mpq_data_valid, mpq_data, mpq_cmd_valid, mpq_cmd, mpq_index, mpq_value,
        output mpq_busy, mpq_done,
        input  heap_size, err, err_cnt, seq_done
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready,
        input  hc_valid, hc_cmd, hc_index, hc_value,
        output hc_ready,
        output mpq_data_valid, mpq_data, mpq_cmd_valid, mpq_cmd, mpq_index, mpq_value,
        input  mpq_busy, mpq_done,
        output heap_size, err, err_cnt, seq_done
    );
endinterface

// File: rtl/mpq_host_sequencer.sv
// rtl/mpq_host_sequencer.sv - load-burst and command sequencer in front of the MPQ
module mpq_host_sequencer #(
    parameter int MAX_N     = 32,
    parameter int CMD_DEPTH = 8,
    parameter int DW        = 8
) (
    input  logic                clk,
    input  logic                rst,
    mpq_host_sequencer_if.slave bus
);

    localparam int CW = $clog2(MAX_N + 1);  // element count 0..MAX_N
    localparam int AW = $clog2(MAX_N);      // load buffer address
    localparam int PW = $clog2(CMD_DEPTH);  // FIFO pointer
    localparam int EW = 3 + 2 * DW;         // FIFO entry {cmd, index, value}

    typedef enum logic [2:0] {
        LOAD,
        BURST,
        WAIT_RDY,
        ISSUE,
        HOLD,
        DRAIN,
        FINISH
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0] load_buf [MAX_N];
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] burst_ptr_q;
    logic [CW-1:0] heap_q;

    logic [EW-1:0] fifo_mem [CMD_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   fifo_cnt_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    logic [2:0]    head_cmd;
    logic [DW-1:0] head_index;
    logic [DW-1:0] head_value;
    logic [DW-1:0] heap_ext;
    logic          head_legal;

    logic [2:0]    cmd_q;
    logic [DW-1:0] index_q;
    logic [DW-1:0] value_q;
    logic          err_q;
    logic [7:0]    err_cnt_q;

    logic          accept;
    logic          burst_last;
    logic          issue_cmd;
    logic          drop_cmd;
    logic          in_ready_c;
    logic          hc_ready_c;
    logic          data_valid_c;
    logic          cmd_valid_c;

    assign fifo_full  = (fifo_cnt_q == (PW + 1)'(CMD_DEPTH));
    assign fifo_empty = (fifo_cnt_q == '0);
    assign hc_ready_c = !fifo_full && (state_q != DRAIN) && (state_q != FINISH);
    assign push       = bus.hc_valid && hc_ready_c;

    assign {head_cmd, head_index, head_value} = fifo_mem[rd_ptr_q];
    assign heap_ext   = DW'(heap_q);
    assign burst_last = (CW'(burst_ptr_q) == cnt_q - CW'(1));

    // Screen the FIFO head against the shadow heap size before it reaches the MPQ.
    always_comb begin
        head_legal = 1'b1;
        case (head_cmd)
            3'd1:          if (heap_q == '0) head_legal = 1'b0;
            3'd2:          if (head_index == '0 || head_index > heap_ext) head_legal = 1'b0;
            3'd3:          if (heap_q == CW'(MAX_N)) head_legal = 1'b0;
            3'd5, 3'd6,
            3'd7:          head_legal = 1'b0;
            default:       head_legal = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_d      = state_q;
        in_ready_c   = 1'b0;
        accept       = 1'b0;
        data_valid_c = 1'b0;
        cmd_valid_c  = 1'b0;
        pop          = 1'b0;
        issue_cmd    = 1'b0;
        drop_cmd     = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready_c = 1'b1;
                accept     = bus.in_valid;
                if (bus.in_valid && (bus.in_last || cnt_q == CW'(MAX_N - 1))) state_d = BURST;
            end
            BURST: begin
                data_valid_c = 1'b1;
                if (burst_last) state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (!bus.mpq_busy && !fifo_empty) begin
                    pop = 1'b1;
                    if (head_legal) begin
                        issue_cmd = 1'b1;
                        state_d   = ISSUE;
                    end else begin
                        drop_cmd  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                cmd_valid_c = 1'b1;
                state_d     = (cmd_q == 3'd4) ? DRAIN : HOLD;
            end
            HOLD:    state_d = WAIT_RDY;
            DRAIN:   if (bus.mpq_done) state_d = FINISH;
            FINISH:  state_d = FINISH;
            default: state_d = LOAD;
        endcase
    end

    // Load buffer storage; contents are only observed through the burst pointer.
    always_ff @(posedge clk) begin
        if (accept) load_buf[cnt_q[AW-1:0]] <= bus.in_data;
    end

    // Count of accepted load elements.
    always_ff @(posedge clk) begin
        if (rst)         cnt_q <= '0;
        else if (accept) cnt_q <= cnt_q + CW'(1);
    end

    // Burst read pointer, parked at zero outside BURST.
    always_ff @(posedge clk) begin
        if (rst || state_q != BURST) burst_ptr_q <= '0;
        else                         burst_ptr_q <= burst_ptr_q + AW'(1);
    end

    // Shadow heap size: seeded by the burst, tracked by issued extract/insert.
    always_ff @(posedge clk) begin
        if (rst) begin
            heap_q <= '0;
        end else if (state_q == BURST && burst_last) begin
            heap_q <= cnt_q;
        end else if (state_q == ISSUE) begin
            if (cmd_q == 3'd1)      heap_q <= heap_q - CW'(1);
            else if (cmd_q == 3'd3) heap_q <= heap_q + CW'(1);
        end
    end

    // Issued command registers hold their values between issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q   <= '0;
            index_q <= '0;
            value_q <= '0;
        end else if (issue_cmd) begin
            cmd_q   <= head_cmd;
            index_q <= head_index;
            value_q <= head_value;
        end
    end

    // Sticky error flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (drop_cmd) begin
            err_q <= 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    // Command FIFO storage.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {bus.hc_cmd, bus.hc_index, bus.hc_value};
    end

    // Command FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + (PW + 1)'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - (PW + 1)'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign bus.in_ready       = in_ready_c;
    assign bus.hc_ready       = hc_ready_c;
    assign bus.mpq_data_valid = data_valid_c;
    assign bus.mpq_data       = data_valid_c ? load_buf[burst_ptr_q] : '0;
    assign bus.mpq_cmd_valid  = cmd_valid_c;
    assign bus.mpq_cmd        = cmd_q;
    assign bus.mpq_index      = index_q;
    assign bus.mpq_value      = value_q;
    assign bus.heap_size      = 6'(heap_q);
    assign bus.err            = err_q;
    assign bus.err_cnt        = err_cnt_q;
    assign bus.seq_done       = (state_q == FINISH);

endmodule
